target_plot_extractor: RTL
==========================

TARGET_PLOT_EXTRACTOR -- requirements
Module: target_plot_extractor

Interface
REQ-001 The module SHALL have parameter MIN_SWEEPS, default 3: minimum consecutive-associated sweeps for a plot.
REQ-002 The module SHALL have parameter RANGE_TOL, default 2: maximum |hit range - reference range| in bins for association.
REQ-003 The module SHALL have parameter MISS_LIMIT, default 2: consecutive unassociated sweeps that close a track.
REQ-004 The module SHALL have port clk, input, 1: single clock; all logic is rising-edge.
REQ-005 The module SHALL have port resset, input, 1: asynchronous, active-high reset.
REQ-006 The module SHALL have port bear, input, 12: azimuth code of the current sweep.
REQ-007 The module SHALL have port range, input, 10: range bin counter within the sweep.
REQ-008 The module SHALL have port video, input, 1: target video (simulated target or target_ref).
REQ-009 The module SHALL have port plot_valid, output, 1: plot available.
REQ-010 The module SHALL have port plot_ready, input, 1: consumer accepts the plot.
REQ-011 The module SHALL have ports plot_bear_start and plot_bear_end, output, 12 each: first and last associated sweep bearing.
REQ-012 The module SHALL have port plot_range, output, 10: reference range of the plot.
REQ-013 The module SHALL have port plot_drop, output, 1: one-cycle pulse when a hit sweep is discarded.

Function
REQ-014 bear, range and video SHALL be registered once; all detection uses registered values.
REQ-015 Sweep end SHALL be the cycle where the registered bear differs from its previous registered value; the closing sweep bearing is the previous value.
REQ-016 Within a sweep, the first cycle with video=1 SHALL capture hit_range; later hits in the same sweep are ignored.
REQ-017 The state machine SHALL have states IDLE, TRACK and REPORT, evaluated only at sweep end, except for the REPORT handshake.
REQ-018 In IDLE, a sweep with a hit SHALL cause a transition to TRACK with start_bear=last_bear=sweep bearing, ref_range=hit_range, hits=1 and miss=0; a sweep without a hit SHALL leave the state in IDLE.
REQ-019 In TRACK, a hit with |hit_range-ref_range|<=RANGE_TOL SHALL set last_bear=sweep bearing, increment hits (saturating at 255) and set miss=0; ref_range SHALL remain unchanged.
REQ-020 In TRACK, a sweep with no hit or an out-of-tolerance hit SHALL increment miss; when miss reaches MISS_LIMIT, the state SHALL go to REPORT if hits>=MIN_SWEEPS, otherwise to IDLE.
REQ-021 In REPORT, plot_valid SHALL be 1, and plot_bear_start=start_bear, plot_bear_end=last_bear and plot_range=ref_range SHALL be held stable until the cycle with plot_ready=1.
REQ-022 The handshake cycle SHALL return the state to IDLE, and plot_valid SHALL be 0 on the next cycle.
REQ-023 plot_ready asserted while plot_valid=0 SHALL have no effect.
REQ-024 A sweep with a hit that ends while in REPORT SHALL be discarded and SHALL pulse plot_drop for one cycle; no track is opened.
REQ-025 If a sweep end and the handshake occur in the same cycle, the handshake SHALL take priority, and that sweep SHALL be discarded with plot_drop.
REQ-026 Bearing wrap from 4095 to 0 SHALL need no special handling; plot_bear_end may be numerically less than plot_bear_start.
REQ-027 The range difference SHALL be computed as an unsigned 10-bit absolute value.
REQ-028 The latency from the closing sweep end to plot_valid=1 SHALL be 1 clock.

Reset
REQ-029 While resset=1, the state SHALL be IDLE, and all counters, captured values and outputs SHALL be 0.
REQ-030 Reset while in TRACK or REPORT SHALL discard the pending track or plot without emitting it.
REQ-031 The first sweep end after reset release SHALL be ignored, because the previous bear is invalid.

Configuration
REQ-032 With macro PLOT_CENTER_EN defined, a 12-bit output plot_bear_center SHALL be provided, equal to (start_bear + ((last_bear-start_bear) mod 4096)/2) mod 4096, rounded down, and valid with plot_valid.
REQ-033 With PLOT_CENTER_EN not defined, the plot_bear_center port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 Video at range 100 for bears 10..14, then none -> plot_valid, start=10, end=14, range=100, appearing 1 clock after the bear 16 sweep closes.
REQ-035 Hits at range 100,101,103 for bears 20..22 -> bear 22 counted as a miss; only 2 hits, so back to IDLE and no plot.
REQ-036 Hits for bears 4094..1 at range 50 -> start=4094, end=1; with PLOT_CENTER_EN, center=4095.
REQ-037 plot_ready held 0 for 20 sweeps, with hits present -> fields stable, plot_drop pulses once per hit sweep, and no new plot appears.
REQ-038 resset=1 during REPORT -> plot_valid=0 immediately; after release, no plot appears without new hits.
REQ-039 Hits in bears 30,31 only, with MIN_SWEEPS=3 -> no plot; then hits 40..42 -> plot with start=40, end=42.

Source files
------------

// File: rtl/target_plot_extractor.sv
`default_nettype none
// ============================================================================
// target_plot_extractor: groups consecutive range-associated sweep hits into plots
// Option PLOT_CENTER_EN adds plot_bear_center.  Revision: 1.0
// ============================================================================
module target_plot_extractor #(
  parameter int MIN_SWEEPS = 3,
  parameter int RANGE_TOL  = 2,
  parameter int MISS_LIMIT = 2
) (
  input  logic        clk,
  input  logic        resset,
  input  logic [11:0] bear,
  input  logic [9:0]  range,
  input  logic        video,
  output logic        plot_valid,
  input  logic        plot_ready,
  output logic [11:0] plot_bear_start,
  output logic [11:0] plot_bear_end,
  output logic [9:0]  plot_range,
  output logic        plot_drop
`ifdef PLOT_CENTER_EN
  ,
  output logic [11:0] plot_bear_center
`endif
);

  localparam logic [7:0] C_MIN_SWEEPS = 8'(MIN_SWEEPS);
  localparam logic [7:0] C_MISS_LIMIT = 8'(MISS_LIMIT);
  localparam logic [9:0] C_RANGE_TOL  = 10'(RANGE_TOL);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    REPORT = 2'd2
  } state_t;

  logic [11:0] bear_q, prev_bear_q;
  logic [9:0]  range_q;
  logic        video_q;
  logic        vld_q, prev_vld_q;

  state_t      state_q, state_d;
  logic        first_q, first_d;
  logic        hit_q, hit_d;
  logic [9:0]  hit_range_q, hit_range_d;
  logic [11:0] start_bear_q, start_bear_d;
  logic [11:0] last_bear_q, last_bear_d;
  logic [9:0]  ref_range_q, ref_range_d;
  logic [7:0]  hits_q, hits_d;
  logic [7:0]  miss_q, miss_d;
  logic        drop_q, drop_d;

  logic        w_sweep_end;
  logic        w_closing;
  logic [9:0]  w_diff;
  logic        w_in_tol;
  logic [7:0]  w_miss_inc;

  always_ff @(posedge clk or posedge resset) begin
    if (resset) begin
      bear_q      <= '0;
      prev_bear_q <= '0;
      range_q     <= '0;
      video_q     <= 1'b0;
      vld_q       <= 1'b0;
      prev_vld_q  <= 1'b0;
    end else begin
      bear_q      <= bear;
      prev_bear_q <= bear_q;
      range_q     <= range;
      video_q     <= video;
      vld_q       <= 1'b1;
      prev_vld_q  <= vld_q;
    end
  end

  // A bearing change is only meaningful once both compared samples are real.
  assign w_sweep_end = prev_vld_q && (bear_q != prev_bear_q);
  assign w_closing   = w_sweep_end && !first_q;
  assign w_diff      = (hit_range_q >= ref_range_q) ? (hit_range_q - ref_range_q)
                                                    : (ref_range_q - hit_range_q);
  assign w_in_tol    = (w_diff <= C_RANGE_TOL);
  assign w_miss_inc  = miss_q + 8'd1;

  always_comb begin
    state_d      = state_q;
    first_d      = first_q;
    hit_d        = hit_q;
    hit_range_d  = hit_range_q;
    start_bear_d = start_bear_q;
    last_bear_d  = last_bear_q;
    ref_range_d  = ref_range_q;
    hits_d       = hits_q;
    miss_d       = miss_q;
    drop_d       = 1'b0;

    // The sample on the sweep-end cycle already belongs to the new sweep.
    if (w_sweep_end) begin
      first_d     = 1'b0;
      hit_d       = video_q;
      hit_range_d = video_q ? range_q : '0;
    end else if (!hit_q && video_q) begin
      hit_d       = 1'b1;
      hit_range_d = range_q;
    end

    case (state_q)
      IDLE: begin
        if (w_closing && hit_q) begin
          state_d      = TRACK;
          start_bear_d = prev_bear_q;
          last_bear_d  = prev_bear_q;
          ref_range_d  = hit_range_q;
          hits_d       = 8'd1;
          miss_d       = 8'd0;
        end
      end
      TRACK: begin
        if (w_closing) begin
          if (hit_q && w_in_tol) begin
            last_bear_d = prev_bear_q;
            hits_d      = (hits_q == 8'hFF) ? hits_q : (hits_q + 8'd1);
            miss_d      = 8'd0;
          end else begin
            miss_d = w_miss_inc;
            if (w_miss_inc >= C_MISS_LIMIT) begin
              state_d = (hits_q >= C_MIN_SWEEPS) ? REPORT : IDLE;
            end
          end
        end
      end
      REPORT: begin
        if (plot_ready) begin
          state_d = IDLE;
        end
        // Hit sweeps closing while a plot is pending (or being accepted) are lost.
        if (w_closing && hit_q) begin
          drop_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge resset) begin
    if (resset) begin
      state_q      <= IDLE;
      first_q      <= 1'b1;
      hit_q        <= 1'b0;
      hit_range_q  <= '0;
      start_bear_q <= '0;
      last_bear_q  <= '0;
      ref_range_q  <= '0;
      hits_q       <= '0;
      miss_q       <= '0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      first_q      <= first_d;
      hit_q        <= hit_d;
      hit_range_q  <= hit_range_d;
      start_bear_q <= start_bear_d;
      last_bear_q  <= last_bear_d;
      ref_range_q  <= ref_range_d;
      hits_q       <= hits_d;
      miss_q       <= miss_d;
      drop_q       <= drop_d;
    end
  end

  assign plot_valid      = (state_q == REPORT);
  assign plot_bear_start = start_bear_q;
  assign plot_bear_end   = last_bear_q;
  assign plot_range      = ref_range_q;
  assign plot_drop       = drop_q;

`ifdef PLOT_CENTER_EN
  logic [11:0] w_span;
  // Modulo-4096 span keeps the midpoint correct across the 4095->0 wrap.
  assign w_span           = last_bear_q - start_bear_q;
  assign plot_bear_center = start_bear_q + {1'b0, w_span[11:1]};
`endif

endmodule
`default_nettype wire
